// File: rtl/fa4_mem_arbiter_pkg.sv
// fa4_mem_pkg: shared types for the FA4 memory arbiter.
//   arb_state_t : arbiter FSM states (idle / dedicated memory access cycle)
//   arb_port_t  : requesting port identity (instruction fetch / load-store)
package fa4_mem_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_ACCESS = 1'b1
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_t;

endpackage

// File: rtl/fa4_mem_arbiter_if.sv
// fa4_mem_arbiter_if: request/response and memory-side signals of the arbiter.
//   Port I : i_req, i_addr -> i_gnt, i_rvalid
//   Port D : d_req, d_we, d_lock, d_addr, d_wdata -> d_gnt, d_rvalid
//   Shared : rdata (registered read data), busy
//   Memory : mem_re, mem_we, mem_addr, mem_wdata -> mem_rdata (combinational)
// Handshake: a requester raises req with a stable payload and holds both until
// it sees its gnt pulse (gnt is the "ready"); read data is returned later as a
// one-cycle rvalid pulse with rdata, and is never back-pressured.
// Modports: slave = the arbiter, master = requesters plus the memory model.
interface fa4_mem_arbiter_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic          d_req;
    logic          d_we;
    logic          d_lock;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_lock, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, d_gnt, d_rvalid, rdata,
        output mem_re, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_lock, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, d_gnt, d_rvalid, rdata,
        input  mem_re, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/fa4_mem_arbiter_rr_pick2.sv
// fa4_rr_pick2: combinational two-way round-robin winner select with D lock.
//   i_req, d_req : current requests
//   last         : port granted most recently
//   lock_q       : D asked to keep ownership for its next request
//   pick_valid   : some port is requesting
//   pick_port    : winning port (meaningful only when pick_valid)
module fa4_rr_pick2
    import fa4_mem_pkg::*;
(
    input  logic      i_req,
    input  logic      d_req,
    input  arb_port_t last,
    input  logic      lock_q,
    output logic      pick_valid,
    output arb_port_t pick_port
);
    always_comb begin
        pick_valid = i_req | d_req;
        pick_port  = PORT_I;
        if (d_req && !i_req) begin
            pick_port = PORT_D;
        end else if (d_req && i_req) begin
            // Lock only extends an ownership D already holds; otherwise
            // the port that did not go last wins.
            if ((last == PORT_D) && lock_q)
                pick_port = PORT_D;
            else if (last == PORT_I)
                pick_port = PORT_D;
            else
                pick_port = PORT_I;
        end
    end
endmodule

// File: rtl/fa4_mem_arbiter.sv
// fa4_mem_arbiter: shares one single-port memory between instruction fetch
// (port I, read-only) and load/store (port D, read/write).
//   clock   : rising-edge clock
//   reset_L : synchronous active-low reset
//   bus     : fa4_mem_arbiter_if.slave (requests, grants, rdata, memory side)
// A grant in IDLE latches the request; the following ACCESS cycle drives the
// memory; read data and rvalid appear registered one cycle later.
module fa4_mem_arbiter
    import fa4_mem_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 8
)(
    input  logic clock,
    input  logic reset_L,
    fa4_mem_arbiter_if.slave bus
);
    arb_state_t    r_state;
    arb_port_t     r_acc_port;
    arb_port_t     r_last;
    logic          r_lock_q;
    logic          r_acc_we;
    logic [AW-1:0] r_acc_addr;
    logic [DW-1:0] r_acc_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_i_rvalid;
    logic          r_d_rvalid;

    logic          w_pick_valid;
    arb_port_t     w_pick_port;
    logic          w_grant;
    logic          w_access;

    fa4_rr_pick2 u_pick (
        .i_req      (bus.i_req),
        .d_req      (bus.d_req),
        .last       (r_last),
        .lock_q     (r_lock_q),
        .pick_valid (w_pick_valid),
        .pick_port  (w_pick_port)
    );

    // Grants and memory strobes are masked by reset so nothing is accepted
    // and no write can land while reset_L is low.
    assign w_grant  = reset_L && (r_state == ARB_IDLE) && w_pick_valid;
    assign w_access = reset_L && (r_state == ARB_ACCESS);

    assign bus.i_gnt     = w_grant && (w_pick_port == PORT_I);
    assign bus.d_gnt     = w_grant && (w_pick_port == PORT_D);
    assign bus.mem_re    = w_access && !r_acc_we;
    assign bus.mem_we    = w_access && r_acc_we;
    assign bus.mem_addr  = w_access ? r_acc_addr  : '0;
    assign bus.mem_wdata = w_access ? r_acc_wdata : '0;
    assign bus.busy      = (r_state == ARB_ACCESS);
    assign bus.rdata     = r_rdata;
    assign bus.i_rvalid  = r_i_rvalid;
    assign bus.d_rvalid  = r_d_rvalid;

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            r_state     <= ARB_IDLE;
            r_acc_port  <= PORT_I;
            r_last      <= PORT_D;
            r_lock_q    <= 1'b0;
            r_acc_we    <= 1'b0;
            r_acc_addr  <= '0;
            r_acc_wdata <= '0;
            r_rdata     <= '0;
            r_i_rvalid  <= 1'b0;
            r_d_rvalid  <= 1'b0;
        end else begin
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            if (r_state == ARB_IDLE) begin
                if (w_pick_valid) begin
                    r_state    <= ARB_ACCESS;
                    r_acc_port <= w_pick_port;
                    r_last     <= w_pick_port;
                    if (w_pick_port == PORT_D) begin
                        r_acc_addr  <= bus.d_addr;
                        r_acc_we    <= bus.d_we;
                        r_acc_wdata <= bus.d_wdata;
                        r_lock_q    <= bus.d_lock;
                    end else begin
                        r_acc_addr  <= bus.i_addr;
                        r_acc_we    <= 1'b0;
                        r_acc_wdata <= '0;
                        r_lock_q    <= 1'b0;
                    end
                end
            end else begin
                r_state <= ARB_IDLE;
                if (!r_acc_we) begin
                    r_rdata    <= bus.mem_rdata;
                    r_i_rvalid <= (r_acc_port == PORT_I);
                    r_d_rvalid <= (r_acc_port == PORT_D);
                end
            end
        end
    end
endmodule

// File: tb/tb_fa4_mem_arbiter.sv
module tb_fa4_mem_arbiter;
    logic clock;
    logic reset_L;
    logic preload;
    logic [7:0] mem [256];
    int n_checks;
    int n_errors;

    fa4_mem_arbiter_if #(.DW(8), .AW(8)) bus ();

    fa4_mem_arbiter #(.DW(8), .AW(8)) dut (
        .clock   (clock),
        .reset_L (reset_L),
        .bus     (bus.slave)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // memory model: combinational read, write on the rising edge
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clock) begin
        if (preload) begin
            for (int a = 0; a < 256; a++) mem[a] <= 8'h00;
            mem[8'h10] <= 8'hA5;
            mem[8'hFF] <= 8'h5A;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    typedef struct {
        logic       ireq;
        logic [7:0] iaddr;
        logic       dreq;
        logic       dwe;
        logic       dlock;
        logic [7:0] daddr;
        logic [7:0] dwdata;
        logic [30:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic ireq, input logic [7:0] iaddr, input logic dreq,
        input logic dwe, input logic dlock, input logic [7:0] daddr,
        input logic [7:0] dwd,
        input logic ig, input logic dg, input logic irv, input logic drv,
        input logic [7:0] rd, input logic re, input logic we,
        input logic [7:0] ma, input logic [7:0] mwd, input logic bsy);
        vec_t v;
        v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe;
        v.dlock = dlock; v.daddr = daddr; v.dwdata = dwd;
        v.exp = {ig, dg, irv, drv, rd, re, we, ma, mwd, bsy};
        return v;
    endfunction

    function automatic logic [30:0] actual();
        return {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.rdata,
                bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // driver tasks
    task automatic drive_idle();
        bus.i_req = 1'b0; bus.i_addr = 8'h00;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_lock = 1'b0;
        bus.d_addr = 8'h00; bus.d_wdata = 8'h00;
    endtask

    task automatic drive_vec(input vec_t v);
        bus.i_req = v.ireq; bus.i_addr = v.iaddr;
        bus.d_req = v.dreq; bus.d_we = v.dwe; bus.d_lock = v.dlock;
        bus.d_addr = v.daddr; bus.d_wdata = v.dwdata;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        drive_idle();
        reset_L = 1'b0;
        preload = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        preload = 1'b0;
        reset_L = 1'b1;
        @(negedge clock);
        chk("reset_outputs", {1'b0, actual()}, 32'h0);

        // single read, D write then read, contention, lock, top address
        tbl.push_back(mk(1,8'h10,0,0,0,8'h00,8'h00, 1,0,0,0,8'h00, 0,0,8'h00,8'h00,0));
        tbl.push_back(mk(0,8'h00,0,0,0,8'h00,8'h00, 0,0,0,0,8'h00, 1,0,8'h10,8'h00,1));
        tbl.push_back(mk(0,8'h00,0,0,0,8'h00,8'h00, 0,0,1,0,8'hA5, 0,0,8'h00,8'h00,0));
        tbl.push_back(mk(0,8'h00,1,1,0,8'h20,8'h3C, 0,1,0,0,8'hA5, 0,0,8'h00,8'h00,0));
        tbl.push_back(mk(0,8'h00,0,0,0,8'h00,8'h00, 0,0,0,0,8'hA5, 0,1,8'h20,8'h3C,1));
        tbl.push_back(mk(0,8'h00,1,0,0,8'h20,8'h00, 0,1,0,0,8'hA5, 0,0,8'h00,8'h00,0));
        tbl.push_back(mk(0,8'h00,0,0,0,8'h00,8'h00, 0,0,0,0,8'hA5, 1,0,8'h20,8'h00,1));
        tbl.push_back(mk(0,8'h00,0,0,0,8'h00,8'h00, 0,0,0,1,8'h3C, 0,0,8'h00,8'h00,0));
        tbl.push_back(mk(1,8'h10,1,0,0,8'h20,8'h00, 1,0,0,0,8'h3C, 0,0,8'h00,8'h00,0));
        tbl.push_back(mk(1,8'h10,1,0,0,8'h20,8'h00, 0,0,0,0,8'h3C, 1,0,8'h10,8'h00,1));
        tbl.push_back(mk(1,8'h10,1,0,0,8'h20,8'h00, 0,1,1,0,8'hA5, 0,0,8'h00,8'h00,0));
        tbl.push_back(mk(1,8'h10,1,0,0,8'h20,8'h00, 0,0,0,0,8'hA5, 1,0,8'h20,8'h00,1));
        tbl.push_back(mk(1,8'h10,1,0,0,8'h20,8'h00, 1,0,0,1,8'h3C, 0,0,8'h00,8'h00,0));
        tbl.push_back(mk(1,8'h10,1,0,0,8'h20,8'h00, 0,0,0,0,8'h3C, 1,0,8'h10,8'h00,1));
        tbl.push_back(mk(1,8'h10,1,0,0,8'h20,8'h00, 0,1,1,0,8'hA5, 0,0,8'h00,8'h00,0));
        tbl.push_back(mk(1,8'h10,1,0,0,8'h20,8'h00, 0,0,0,0,8'hA5, 1,0,8'h20,8'h00,1));
        tbl.push_back(mk(1,8'h10,1,0,0,8'h20,8'h00, 1,0,0,1,8'h3C, 0,0,8'h00,8'h00,0));
        tbl.push_back(mk(1,8'h10,1,0,1,8'h20,8'h00, 0,0,0,0,8'h3C, 1,0,8'h10,8'h00,1));
        tbl.push_back(mk(1,8'h10,1,0,1,8'h20,8'h00, 0,1,1,0,8'hA5, 0,0,8'h00,8'h00,0));
        tbl.push_back(mk(1,8'h10,1,0,1,8'h20,8'h00, 0,0,0,0,8'hA5, 1,0,8'h20,8'h00,1));
        tbl.push_back(mk(1,8'h10,1,0,1,8'h20,8'h00, 0,1,0,1,8'h3C, 0,0,8'h00,8'h00,0));
        tbl.push_back(mk(1,8'h10,1,0,0,8'h20,8'h00, 0,0,0,0,8'h3C, 1,0,8'h20,8'h00,1));
        tbl.push_back(mk(1,8'h10,1,0,0,8'h20,8'h00, 0,1,0,1,8'h3C, 0,0,8'h00,8'h00,0));
        tbl.push_back(mk(1,8'h10,1,0,0,8'h20,8'h00, 0,0,0,0,8'h3C, 1,0,8'h20,8'h00,1));
        tbl.push_back(mk(1,8'h10,1,0,0,8'h20,8'h00, 1,0,0,1,8'h3C, 0,0,8'h00,8'h00,0));
        tbl.push_back(mk(0,8'h00,0,0,0,8'h00,8'h00, 0,0,0,0,8'h3C, 1,0,8'h10,8'h00,1));
        tbl.push_back(mk(0,8'h00,0,0,0,8'h00,8'h00, 0,0,1,0,8'hA5, 0,0,8'h00,8'h00,0));
        tbl.push_back(mk(1,8'hFF,0,0,0,8'h00,8'h00, 1,0,0,0,8'hA5, 0,0,8'h00,8'h00,0));
        tbl.push_back(mk(0,8'h00,0,0,0,8'h00,8'h00, 0,0,0,0,8'hA5, 1,0,8'hFF,8'h00,1));
        tbl.push_back(mk(0,8'h00,0,0,0,8'h00,8'h00, 0,0,1,0,8'h5A, 0,0,8'h00,8'h00,0));

        for (int k = 0; k < tbl.size(); k++) begin
            @(posedge clock);
            #1;
            drive_vec(tbl[k]);
            @(negedge clock);
            chk($sformatf("vec%0d", k), {1'b0, actual()}, {1'b0, tbl[k].exp});
        end
        chk("mem20_written", {24'h0, mem[8'h20]}, 32'h3C);

        // reset during the access cycle of a D write of 0xFF to 0x30
        @(posedge clock);
        #1;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'h30; bus.d_wdata = 8'hFF;
        @(negedge clock);
        chk("rst_wr_gnt", {31'h0, bus.d_gnt}, 32'h1);
        @(posedge clock);
        #1;
        drive_idle();
        reset_L = 1'b0;
        @(negedge clock);
        chk("rst_wr_strobes", {28'h0, bus.mem_we, bus.mem_re, bus.i_gnt, bus.d_gnt}, 32'h0);
        @(posedge clock);
        @(negedge clock);
        chk("rst_mem30", {24'h0, mem[8'h30]}, 32'h0);
        chk("rst_held_outputs", {1'b0, actual()}, 32'h0);
        @(posedge clock);
        #1;
        reset_L = 1'b1;
        @(negedge clock);
        chk("rst_released", {1'b0, actual()}, 32'h0);
        // last=D and lock_q=0 after reset: I must win contention
        @(posedge clock);
        #1;
        bus.i_req = 1'b1; bus.i_addr = 8'h10;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_lock = 1'b1; bus.d_addr = 8'h20;
        @(negedge clock);
        chk("post_rst_gnt", {30'h0, bus.i_gnt, bus.d_gnt}, 32'h2);
        @(posedge clock);
        #1;
        drive_idle();
        @(negedge clock);
        chk("post_rst_access", {22'h0, bus.busy, bus.mem_re, bus.mem_addr}, {22'h0, 2'b11, 8'h10});
        @(posedge clock);
        @(negedge clock);
        chk("post_rst_rdata", {23'h0, bus.i_rvalid, bus.rdata}, {23'h0, 1'b1, 8'hA5});
        chk("mem30_final", {24'h0, mem[8'h30]}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fa4_mem_arbiter.md
# fa4_mem_arbiter

Two-port arbiter that shares the single-port `Memory` (DW=8, AW=8) between the instruction-fetch unit (port I, read-only) and the load/store unit (port D, read/write). It accepts one request at a time, sequences it onto the memory in a dedicated access cycle, and returns registered read data. Grants alternate round-robin, and port D has a lock that keeps ownership across read-modify-write sequences. The block sits between the FA4 control FSM and the memory wrapper, which converts `mem_wdata` and `mem_rdata` to the tri-state `Data` bus.

## Interface
Parameters:
- `DW`, 8, memory data width
- `AW`, 8, memory address width

Ports (clock and reset first):
- `clock` in 1: single clock; all state changes on its rising edge
- `reset_L` in 1: reset, synchronous and active-low
- `i_req` in 1: port I read request; held until `i_gnt`
- `i_addr` in AW: port I address; stable while `i_req` is high
- `i_gnt` out 1: port I request accepted this cycle
- `i_rvalid` out 1: `rdata` holds port I read data this cycle
- `d_req` in 1: port D request; held until `d_gnt`
- `d_we` in 1: port D access is a write (1) or a read (0)
- `d_lock` in 1: keep port D ownership for its next request
- `d_addr` in AW: port D address
- `d_wdata` in DW: port D write data
- `d_gnt` out 1: port D request accepted this cycle
- `d_rvalid` out 1: `rdata` holds port D read data this cycle
- `rdata` out DW: registered read data shared by both ports
- `mem_re` out 1: memory read enable
- `mem_we` out 1: memory write enable
- `mem_addr` out AW: memory address
- `mem_wdata` out DW: memory write data
- `mem_rdata` in DW: combinational memory read data
- `busy` out 1: high while the FSM is in `ARB_ACCESS`

## Operation
- FSM states: `ARB_IDLE` and `ARB_ACCESS`. Reset state is `ARB_IDLE`.
- Grant (`ARB_IDLE` only):
  - The winner is chosen combinationally; exactly one of `i_gnt`/`d_gnt` pulses for one cycle.
  - On the grant edge, latch `acc_port`, `acc_addr`, `acc_we` and `acc_wdata`, then go to `ARB_ACCESS`.
  - Port I always latches `acc_we=0`.
- Winner selection:
  - If only one port requests, grant that port.
  - If both request, grant the port that is not `last`.
  - Lock override: if `last=D`, `lock_q=1` and `d_req=1`, grant D even if `i_req=1`.
- `last` register:
  - Reset value is D, so port I wins the first contention.
  - Updated to the granted port on every grant.
- `lock_q` register: captures `d_lock` on a port D grant and clears on a port I grant. Lock can only extend existing D ownership; it never preempts I.
- `ARB_ACCESS` state:
  - `mem_addr` = `acc_addr`, `mem_wdata` = `acc_wdata`.
  - `mem_we` = `acc_we`, `mem_re` = `~acc_we`.
  - Always returns to `ARB_IDLE` the next cycle.
  - On a read, `mem_rdata` is captured into `rdata` at the end of the cycle.
- In `ARB_IDLE`, `mem_re`, `mem_we`, `mem_addr` and `mem_wdata` are all 0.
- `i_rvalid`/`d_rvalid`: registered one-cycle pulse in the cycle after a read `ARB_ACCESS`, for the owning port. No rvalid is produced for writes.
- `rdata` holds its value until the next read completes.
- Reset while `reset_L=0`:
  - `i_gnt`, `d_gnt`, `mem_re` and `mem_we` are forced to 0 combinationally, so no write lands during reset.
  - An in-flight access is abandoned and no rvalid follows.
- Reset values: `rdata`=0, both rvalids=0, `busy`=0, `last`=D, `lock_q`=0, all `mem_*` outputs 0.
- Address width: addresses pass through unmodified; no wrap logic is applied beyond AW bits.

## Timing
- Grant in cycle T, memory access in T+1, rvalid in T+2. Read latency is 2 cycles from grant.
- A write is committed to memory at the rising edge ending T+1.
- Peak throughput is one access per 2 cycles. No grant is issued while `busy`=1.
- `rvalid` for access n coincides with the `ARB_IDLE` cycle that may grant access n+1.
- Requesters drop or change `req` and payload only after seeing `gnt`. A `req` still high in T+1 counts as a new request at T+2.
- `d_lock` is sampled only in the port D grant cycle.

## Structure
- Package `fa4_mem_pkg`:
  - `typedef enum logic {ARB_IDLE, ARB_ACCESS} arb_state_t`
  - `typedef enum logic {PORT_I, PORT_D} arb_port_t`
- Sub-module `fa4_rr_pick2`: combinational winner select. Inputs are `i_req`, `d_req`, `last`, `lock_q`; outputs are `pick_valid` and `pick_port`.
- The remainder of the block (FSM, latch registers, rdata/rvalid registers) stays in `fa4_mem_arbiter`.

## Test plan
- Single read: preload M[0x10]=0xA5; `i_req` with `i_addr`=0x10 at T.
  - Required: `i_gnt` at T, `mem_re`=1 with `mem_addr`=0x10 at T+1, `i_rvalid`=1 with `rdata`=0xA5 at T+2.
- Write then read: D write to 0x20 with data 0x3C, then D read of 0x20.
  - Required: `mem_we` for exactly one cycle, no `d_rvalid` for the write, `d_rvalid` with `rdata`=0x3C after the read.
- Contention after reset: `i_req` and `d_req` both held high continuously.
  - Required: grants alternate I, D, I, D, spaced 2 cycles apart.
- Lock: both ports requesting, `d_lock`=1 on D grants for 3 accesses.
  - Required: D is granted 3 times in a row; I is granted on the first opportunity after `d_lock`=0.
- Reset mid-write: `reset_L`=0 during the `ARB_ACCESS` cycle of a D write of 0xFF to 0x30 (M[0x30]=0x00).
  - Required: `mem_we`=0, M[0x30] remains 0x00, all outputs at reset values, FSM in `ARB_IDLE` with `last`=D afterwards.
